step_pulse_generator: RTL
=========================

# step_pulse_generator

Generates the STEP/DIR/EN pin sequence for one stepper-motor driver chip. Each move is a requested step count with a trapezoidal speed profile: accelerate from a slow start period, cruise at a minimum period, decelerate symmetrically. Sits between the move sequencer (start/steps/dir/done handshake) and the motor-driver pins. The step counter downstream counts the `step_out` rising edges this block produces.

## Interface
- START_PERIOD, 16'd50000: step period (clock cycles, rising edge to rising edge) of the first and last step.
- MIN_PERIOD, 16'd10000: cruise period floor. Must be greater than PULSE_WIDTH.
- ACCEL_STEP, 16'd1000: period change per step while ramping.
- PULSE_WIDTH, 16'd100: `step_out` high time in cycles (≥1).
- DIR_SETUP, 16'd50: cycles `dir_out` is stable before the first step (≥1).

- clock  in  1  system clock; all logic is on the posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle move request; ignored unless idle.
- steps  in  8  step count, sampled with `start`.
- dir  in  1  direction, sampled with `start`.
- abort  in  1  stop the move early, level-sensitive.
- step_out  out  1  STEP pin.
- dir_out  out  1  DIR pin, registered.
- en_n  out  1  driver enable, active low; 1 when idle.
- busy  out  1  high while a move is in progress.
- done  out  1  one-cycle pulse at the end of a move (normal, aborted, or zero-step).
- steps_left  out  8  remaining steps.

## Operation
- Reset values: step_out=0, dir_out=0, en_n=1, busy=0, done=0, steps_left=0. State is IDLE, period=START_PERIOD, ramp_count=0, timer=0.
- State machine: IDLE → SETUP → HIGH ↔ LOW → DONE → IDLE.
- **IDLE:** `start` with steps≠0:
  - latch steps into steps_left and dir into dir_out;
  - set period=START_PERIOD, ramp_count=0, timer=0;
  - go to SETUP.
- **IDLE:** `start` with steps=0 → DONE directly. No pulse, en_n stays 1.
- **SETUP:** hold for DIR_SETUP cycles, then go to HIGH.
- **HIGH:** step_out=1 for PULSE_WIDTH cycles. On exit, steps_left decrements.
- **LOW:** step_out=0 for period−PULSE_WIDTH cycles. On the final LOW cycle:
  - if steps_left=0 → DONE;
  - else update the period, then go to HIGH.
- **Period update** uses the decremented steps_left:
  - decelerate if steps_left ≤ ramp_count: period += ACCEL_STEP (saturates at START_PERIOD), ramp_count −= 1;
  - else accelerate if period > MIN_PERIOD: period −= ACCEL_STEP (saturates at MIN_PERIOD), ramp_count += 1;
  - else hold.
  - Period arithmetic is 17-bit internally, then clamped to 16 bits.
- **DONE:** done=1 for exactly one cycle, then IDLE.
- busy=1 and en_n=0 in SETUP, HIGH and LOW. In DONE, busy=0 and en_n=1.
- **abort:**
  - in SETUP or LOW → DONE next cycle;
  - in HIGH, the pulse completes its full PULSE_WIDTH (no runt pulses), then → DONE;
  - steps_left keeps its value at abort;
  - ignored in IDLE and DONE.
- `start` while not IDLE is ignored; it is not queued.
- dir_out changes only on an accepted `start`.
- ramp_count is 8 bits and never exceeds steps_left + 1, so it cannot wrap.

## Timing
- `start` sampled at edge N: busy=1 and en_n=0 from N+1. First step_out rise at N+1+DIR_SETUP.
- Spacing between consecutive step_out rising edges equals the period in effect for the earlier step.
- done is asserted in the cycle after the last LOW cycle.
- Zero-step start: done high at N+1, busy never asserts.
- Reset mid-move takes effect immediately (asynchronous). step_out drops in the same cycle with no completion pulse.
- Profile is symmetric: the decel steps mirror the accel steps.

## Test plan
Use START=20, MIN=8, ACCEL=4, PW=2, SETUP=3.
- **Reset mid-move:** assert reset_n=0 during HIGH → step_out=0, en_n=1, busy=0 immediately. After release, no spurious done.
- **Zero-step move:** steps=0 start → done pulse at N+1; no step_out activity, en_n stays 1.
- **Short move:** steps=3, dir=1 → dir_out=1 at N+1; first rise at N+4; rise spacings 20 and 16; done 20 cycles after the third rise; each pulse is exactly 2 cycles high.
- **Full profile:** steps=10 → rise spacings 20,16,12,8,8,8,8,12,16; final step period 20; steps_left counts 10→0.
- **Abort during HIGH:** abort asserted in step 4's HIGH → that pulse is 2 cycles wide, then done; steps_left=6; no further rises.
- **Start while busy:** start pulsed with steps=50 during a steps=3 move → ignored; exactly 3 pulses, a single done pulse.

Source files
------------

// File: rtl/step_pulse_generator.sv
// STEP/DIR/EN pin sequencer for one stepper driver. Each move runs a
// trapezoidal period profile: ramp down from START_PERIOD to MIN_PERIOD, cruise, then ramp back up.
module step_pulse_generator #(
    parameter logic [15:0] START_PERIOD = 16'd50000,
    parameter logic [15:0] MIN_PERIOD   = 16'd10000,
    parameter logic [15:0] ACCEL_STEP   = 16'd1000,
    parameter logic [15:0] PULSE_WIDTH  = 16'd100,
    parameter logic [15:0] DIR_SETUP    = 16'd50
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] steps,
    input  logic       dir,
    input  logic       abort,
    output logic       step_out,
    output logic       dir_out,
    output logic       en_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] steps_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] period_q, period_d;
    logic [7:0]  ramp_q, ramp_d;
    logic [7:0]  steps_left_q, steps_left_d;
    logic        dir_q, dir_d;
    logic        abort_q, abort_d;
    logic        step_q, busy_q, en_n_q, done_q;

    logic [15:0] low_len;
    logic [16:0] inc_wide, dec_wide;
    logic [15:0] period_up, period_down;
    logic        active_d;

    // Ramp arithmetic is done one bit wider so overflow/underflow is visible before clamping.
    always_comb begin
        low_len     = period_q - PULSE_WIDTH;
        inc_wide    = {1'b0, period_q} + {1'b0, ACCEL_STEP};
        dec_wide    = {1'b0, period_q} - {1'b0, ACCEL_STEP};
        period_up   = (inc_wide > {1'b0, START_PERIOD}) ? START_PERIOD : inc_wide[15:0];
        period_down = (dec_wide[16] || (dec_wide[15:0] < MIN_PERIOD)) ? MIN_PERIOD
                                                                      : dec_wide[15:0];
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + 16'd1;
        period_d     = period_q;
        ramp_d       = ramp_q;
        steps_left_d = steps_left_q;
        dir_d        = dir_q;
        abort_d      = abort_q;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (start) begin
                    if (steps != 8'd0) begin
                        steps_left_d = steps;
                        dir_d        = dir;
                        period_d     = START_PERIOD;
                        ramp_d       = '0;
                        abort_d      = 1'b0;
                        state_d      = S_SETUP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    timer_d = '0;
                    state_d = S_DONE;
                end else if (timer_q == DIR_SETUP - 16'd1) begin
                    timer_d = '0;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                // An abort seen at any point of the pulse is remembered so the pulse is never cut short.
                if (abort) begin
                    abort_d = 1'b1;
                end
                if (timer_q == PULSE_WIDTH - 16'd1) begin
                    timer_d      = '0;
                    steps_left_d = steps_left_q - 8'd1;
                    state_d      = (abort || abort_q) ? S_DONE : S_LOW;
                end
            end
            S_LOW: begin
                if (abort) begin
                    timer_d = '0;
                    state_d = S_DONE;
                end else if (timer_q == low_len - 16'd1) begin
                    timer_d = '0;
                    if (steps_left_q == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HIGH;
                        if (steps_left_q <= ramp_q) begin
                            period_d = period_up;
                            ramp_d   = ramp_q - 8'd1;
                        end else if (period_q > MIN_PERIOD) begin
                            period_d = period_down;
                            ramp_d   = ramp_q + 8'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                timer_d = '0;
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign active_d = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_LOW);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            period_q     <= START_PERIOD;
            ramp_q       <= '0;
            steps_left_q <= '0;
            dir_q        <= 1'b0;
            abort_q      <= 1'b0;
            step_q       <= 1'b0;
            busy_q       <= 1'b0;
            en_n_q       <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            period_q     <= period_d;
            ramp_q       <= ramp_d;
            steps_left_q <= steps_left_d;
            dir_q        <= dir_d;
            abort_q      <= abort_d;
            step_q       <= (state_d == S_HIGH);
            busy_q       <= active_d;
            en_n_q       <= ~active_d;
            done_q       <= (state_d == S_DONE);
        end
    end

    assign step_out   = step_q;
    assign dir_out    = dir_q;
    assign en_n       = en_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign steps_left = steps_left_q;

endmodule
